// File: rtl/fp_extend_serializer.sv
// fp_extend_serializer: aligns a fixed-point sample to the internal format and shifts it out bit-serially.
// Define FP_SER_MSB_FIRST_EN to shift MSB first; the default build shifts LSB first.
module fp_extend_serializer #(
    parameter int NB_XI  = 16,
    parameter int NBF_XI = 15,
    parameter int NB_XO  = 32,
    parameter int NBF_XO = 30
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [NB_XI-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic              o_first,
    output logic              o_last,
    output logic              o_sat
);

    localparam int WW  = NB_XI + NB_XO;
    localparam int SHL = (NBF_XO >= NBF_XI) ? NBF_XO - NBF_XI : 0;
    localparam int SHR = (NBF_XO >= NBF_XI) ? 0 : NBF_XI - NBF_XO;
    localparam int CW  = (NB_XO > 1) ? $clog2(NB_XO) : 1;
    localparam logic [CW-1:0] LAST     = CW'(NB_XO - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(NB_XO - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [NB_XO-1:0] sr;
    logic [NB_XO-1:0] sr_shift;

    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] shl;
    logic signed [WW-1:0] wide;
    logic [NB_XI:0]       top;
    logic                 sign;
    logic                 overflow;
    logic [NB_XO-1:0]     aligned;
    logic                 accept;

    // Arithmetic shifts give zero-padding or floor truncation of the fraction.
    always_comb begin
        sign     = i_data[NB_XI-1];
        ext      = {{NB_XO{sign}}, i_data};
        shl      = ext <<< SHL;
        wide     = shl >>> SHR;
        top      = wide[WW-1:NB_XO-1];
        overflow = ~((&top) | ~(|top));
        if (overflow) begin
            aligned = {sign, {(NB_XO-1){~sign}}};
        end else begin
            aligned = wide[NB_XO-1:0];
        end
    end

    assign o_ready = ~i_rst &&
                     (state == IDLE || (state == SHIFT && cnt == LAST));
    assign accept  = i_valid && o_ready;

`ifdef FP_SER_MSB_FIRST_EN
    assign o_bit    = sr[NB_XO-1];
    assign sr_shift = {sr[NB_XO-2:0], 1'b0};
`else
    assign o_bit    = sr[0];
    assign sr_shift = {1'b0, sr[NB_XO-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            o_bit_valid <= 1'b0;
            o_first     <= 1'b0;
            o_last      <= 1'b0;
            o_sat       <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            cnt         <= '0;
            sr          <= aligned;
            o_bit_valid <= 1'b1;
            o_first     <= 1'b1;
            o_last      <= 1'b0;
            o_sat       <= overflow;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state       <= IDLE;
                cnt         <= '0;
                sr          <= '0;
                o_bit_valid <= 1'b0;
                o_first     <= 1'b0;
                o_last      <= 1'b0;
                o_sat       <= 1'b0;
            end else begin
                cnt     <= cnt + 1'b1;
                sr      <= sr_shift;
                o_first <= 1'b0;
                o_last  <= (cnt == PRE_LAST);
            end
        end
    end

endmodule

// File: tb/tb_fp_extend_serializer.sv
// Scoreboard bench for fp_extend_serializer: default Q1.15->Q2.30 instance
// plus a Q4.12->Q1.15 instance exercising saturation.
module tb_fp_extend_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_vld, a_rdy, a_bit, a_bv, a_first, a_last, a_sat;
    logic [15:0] a_data;
    logic        b_rst, b_vld, b_rdy, b_bit, b_bv, b_first, b_last, b_sat;
    logic [15:0] b_data;

    fp_extend_serializer dut_a (
        .clk(clk), .i_rst(a_rst), .i_data(a_data), .i_valid(a_vld),
        .o_ready(a_rdy), .o_bit(a_bit), .o_bit_valid(a_bv),
        .o_first(a_first), .o_last(a_last), .o_sat(a_sat)
    );

    fp_extend_serializer #(
        .NB_XI(16), .NBF_XI(12), .NB_XO(16), .NBF_XO(15)
    ) dut_b (
        .clk(clk), .i_rst(b_rst), .i_data(b_data), .i_valid(b_vld),
        .o_ready(b_rdy), .o_bit(b_bit), .o_bit_valid(b_bv),
        .o_first(b_first), .o_last(b_last), .o_sat(b_sat)
    );

    typedef struct {
        longint word;
        bit     sat;
        int     acc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        cur[2];
    exp_t        ea, eb;
    int          k[2];
    longint      wacc[2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          pa = 0, pb = 0;
    logic [15:0] la_d, lb_d;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Value-level model: scale by 2^(NBF_XO-NBF_XI) with floor, then clamp.
    function automatic exp_t model(input int nbxi, input int nbfxi,
                                   input int nbxo, input int nbfxo,
                                   input logic [15:0] d);
        exp_t   e;
        longint v, hi, lo;
        v = longint'(d);
        if (d[nbxi-1]) v = v - (longint'(1) << nbxi);
        if (nbfxo >= nbfxi) v = v * (longint'(1) << (nbfxo - nbfxi));
        else v = v >>> (nbfxi - nbfxo);
        hi = (longint'(1) << (nbxo - 1)) - 1;
        lo = -(longint'(1) << (nbxo - 1));
        e.sat = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        e.word = v & ((longint'(1) << nbxo) - 1);
        e.acc  = 0;
        return e;
    endfunction

    task automatic mon(input int id, input int nbxo, input logic rst,
                       input logic bv, input logic b, input logic fi,
                       input logic la, input logic sa, input logic rdy);
        string p;
        int    idx;
        int    sz;
        p = (id == 0) ? "A_" : "B_";
        if (rst) begin
            k[id] = 0;
            chk({p, "ready_in_reset"}, rdy, 0);
            return;
        end
        chk({p, "ready"}, rdy, !bv || la);
        if (!bv) begin
            if (k[id] != 0) chk({p, "frame_gap_bits"}, k[id], 0);
            k[id] = 0;
            return;
        end
        if (k[id] == 0) begin
            chk({p, "first"}, fi, 1);
            sz = (id == 0) ? qa.size() : qb.size();
            chk({p, "frame_expected"}, sz > 0, 1);
            if (sz > 0) begin
                if (id == 0) cur[0] = qa.pop_front();
                else cur[1] = qb.pop_front();
            end
            chk({p, "first_latency"}, cyc, cur[id].acc);
            wacc[id] = 0;
        end else begin
            chk({p, "first_mid"}, fi, 0);
        end
`ifdef FP_SER_MSB_FIRST_EN
        idx = nbxo - 1 - k[id];
`else
        idx = k[id];
`endif
        wacc[id][idx] = b;
        chk({p, "sat_held"}, sa, cur[id].sat);
        if (k[id] == nbxo - 1) begin
            chk({p, "last"}, la, 1);
            chk({p, "word"}, wacc[id], cur[id].word);
            k[id] = 0;
        end else begin
            chk({p, "last_mid"}, la, 0);
            k[id]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 32, a_rst, a_bv, a_bit, a_first, a_last, a_sat, a_rdy);
        mon(1, 16, b_rst, b_bv, b_bit, b_first, b_last, b_sat, b_rdy);
        pa   = a_vld && a_rdy;
        pb   = b_vld && b_rdy;
        la_d = a_data;
        lb_d = b_data;
    end

    always @(posedge clk) begin
        cyc++;
        if (pa) begin
            ea     = model(16, 15, 32, 30, la_d);
            ea.acc = cyc;
            qa.push_back(ea);
        end
        if (pb) begin
            eb     = model(16, 12, 16, 15, lb_d);
            eb.acc = cyc;
            qb.push_back(eb);
        end
    end

    task automatic send_a(input logic [15:0] d);
        int   t;
        logic r;
        t      = 0;
        a_vld  = 1'b1;
        a_data = d;
        do begin
            @(negedge clk);
            r = a_rdy;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 300);
        chk("A_send_accepted", r, 1);
        a_vld = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d);
        int   t;
        logic r;
        t      = 0;
        b_vld  = 1'b1;
        b_data = d;
        do begin
            @(negedge clk);
            r = b_rdy;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 300);
        chk("B_send_accepted", r, 1);
        b_vld = 1'b0;
    endtask

    initial begin
        int t;
        a_rst = 1'b1; a_vld = 1'b0; a_data = '0;
        b_rst = 1'b1; b_vld = 1'b0; b_data = '0;
        k[0] = 0; k[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("A_reset_bit", a_bit, 0);
        chk("A_reset_valid", a_bv, 0);
        chk("A_reset_first", a_first, 0);
        chk("A_reset_last", a_last, 0);
        chk("A_reset_sat", a_sat, 0);
        chk("A_reset_ready", a_rdy, 0);
        chk("B_reset_valid", b_bv, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk("A_ready_after_reset", a_rdy, 1);
        chk("B_ready_after_reset", b_rdy, 1);

        send_a(16'h4000);
        repeat (40) @(posedge clk);
        #1;
        send_a(16'h8000);
        repeat (35) @(posedge clk);
        #1;
        send_a(16'h0001);
        send_a(16'hFFFF);
        repeat (36) @(posedge clk);
        #1;

        // Abort a frame at bit 10, then expect a clean frame afterwards.
        send_a(16'h4000);
        repeat (10) @(posedge clk);
        #1;
        chk("A_midframe_valid", a_bv, 1);
        a_rst = 1'b1;
        a_vld = 1'b1;
        a_data = 16'h1234;
        @(posedge clk);
        #1;
        qa.delete();
        chk("A_abort_valid", a_bv, 0);
        chk("A_abort_bit", a_bit, 0);
        chk("A_abort_first", a_first, 0);
        chk("A_abort_last", a_last, 0);
        chk("A_abort_sat", a_sat, 0);
        chk("A_abort_ready", a_rdy, 0);
        @(posedge clk);
        #1;
        a_vld = 1'b0;
        a_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("A_idle_after_abort", a_bv, 0);
        send_a(16'h4000);

        send_b(16'h1000);
        send_b(16'hF000);
        send_b(16'h8000);
        send_b(16'h7FFF);
        send_b(16'h0FFF);

        for (int i = 0; i < 30; i++) begin
            send_a(16'($urandom));
            repeat ($urandom_range(0, 3) * 11) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 30; i++) begin
            send_b(16'($urandom));
            repeat ($urandom_range(0, 3) * 7) @(posedge clk);
            #1;
        end

        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || k[0] != 0 ||
                k[1] != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        chk("drain_pending", qa.size() + qb.size() + k[0] + k[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
